// File: rtl/serial_full_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop consume one operand bit per clock, LSB first.
// Operands load in parallel on an accepted start; the result is presented in parallel with a one-cycle done pulse.
module serial_full_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_s;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             s_bit;
    logic             carry_next;
    logic [WIDTH:0]   s_cat;
    logic             load;
    logic             last_step;

    // Full-adder cell on the current LSBs; s_cat[WIDTH:1] is the partial sum shifted with s_bit at the MSB.
    always_comb begin
        s_bit      = sh_a[0] ^ sh_b[0] ^ carry;
        carry_next = (sh_a[0] & sh_b[0]) | (carry & (sh_a[0] ^ sh_b[0]));
        s_cat      = {s_bit, sh_s};
        load       = start && ((state == IDLE) || (state == DONE));
        last_step  = (state == RUN) && (cnt == LAST_STEP);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            sh_a  <= '0;
            sh_b  <= '0;
            sh_s  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= last_step;
            if (load) begin
                sh_a  <= a;
                sh_b  <= b;
                carry <= cin;
                sh_s  <= '0;
                cnt   <= '0;
            end else if (state == RUN) begin
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                sh_s  <= s_cat[WIDTH:1];
                carry <= carry_next;
                cnt   <= cnt + 1'b1;
            end
            // Published result only moves on the final bit-step; it holds through the next RUN.
            if (last_step) begin
                sum  <= s_cat[WIDTH:1];
                cout <= carry_next;
            end
        end
    end

endmodule

// File: tb/tb_serial_full_adder.sv
// Self-checking bench for serial_full_adder: directed and random adds on an 8-bit instance,
// exhaustive adds on 2-bit and 1-bit instances, all compared against plain integer addition.
module tb_serial_full_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start_s = 1'b0;
    logic [1:0] a_s = '0;
    logic [1:0] b_s = '0;
    logic       cin_s = 1'b0;
    logic       busy2, done2, cout2;
    logic [1:0] sum2;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int         errors = 0;
    int         checks = 0;
    logic [8:0] last_result = '0;

    always #5 clk = ~clk;

    serial_full_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_full_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start_s), .a(a_s), .b(b_s), .cin(cin_s),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_full_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_s), .a(a_s[0:0]), .b(b_s[0:0]), .cin(cin_s),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int t;
        t = int'(x) + int'(y) + int'(c);
        return 9'(t);
    endfunction

    // Pulse start for one edge; operands are scrambled right after the accepting edge.
    task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("busy_accept", busy, 1);
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
    endtask

    // Counts edges until done; busy must stay high and the old result must hold meanwhile.
    task automatic waitResult(input logic [7:0] x, input logic [7:0] y, input logic c,
                              input int gap, input bit repulse);
        logic [8:0] expv;
        int n;
        expv = model8(x, y, c);
        n = 0;
        while (n <= 20) begin
            n++;
            if (repulse) begin
                start = (n == 3);
                if (n == 3) begin
                    a = 8'h12;
                    b = 8'h34;
                    cin = 1'b0;
                end
            end
            tick();
            if (done) break;
            checkOutput("busy_run", busy, 1);
            checkOutput("hold_result", {cout, sum}, last_result);
        end
        if (repulse) start = 1'b0;
        checkOutput("latency", n, gap);
        checkOutput("result", {cout, sum}, expv);
        checkOutput("busy_at_done", busy, 0);
        last_result = expv;
    endtask

    task automatic runSmall(input logic [1:0] x, input logic [1:0] y, input logic c);
        int lat2, lat1;
        logic [2:0] r2;
        logic [1:0] r1;
        logic [2:0] e2;
        logic [1:0] e1;
        lat2 = 0;
        lat1 = 0;
        r2 = '0;
        r1 = '0;
        a_s = x;
        b_s = y;
        cin_s = c;
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            if (done2 && lat2 == 0) begin lat2 = n; r2 = {cout2, sum2}; end
            if (done1 && lat1 == 0) begin lat1 = n; r1 = {cout1, sum1}; end
        end
        e2 = 3'(int'(x) + int'(y) + int'(c));
        e1 = 2'(int'(x[0]) + int'(y[0]) + int'(c));
        checkOutput("w2_latency", lat2, 2);
        checkOutput("w2_result", r2, e2);
        checkOutput("w1_latency", lat1, 1);
        checkOutput("w1_result", r1, e1);
    endtask

    initial begin
        int pulses;
        logic [7:0] rx, ry;
        logic rc;

        tick();
        tick();
        rst = 1'b0;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_result", {cout, sum}, 0);
        checkOutput("rst_w2", {busy2, done2, cout2, sum2}, 0);
        checkOutput("rst_w1", {busy1, done1, cout1, sum1}, 0);

        applyStimulus(8'h00, 8'h00, 1'b0);
        waitResult(8'h00, 8'h00, 1'b0, 8, 1'b0);
        tick();
        checkOutput("done_one_cycle", done, 0);

        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitResult(8'hFF, 8'h01, 1'b0, 8, 1'b0);
        tick();
        applyStimulus(8'h3C, 8'h0F, 1'b1);
        waitResult(8'h3C, 8'h0F, 1'b1, 8, 1'b0);
        tick();

        applyStimulus(8'hA5, 8'h5A, 1'b1);
        waitResult(8'hA5, 8'h5A, 1'b1, 8, 1'b1);
        tick();
        checkOutput("ignored_start", busy, 0);

        a = 8'h80;
        b = 8'h80;
        cin = 1'b0;
        start = 1'b1;
        tick();
        for (int rep = 0; rep < 3; rep++)
            waitResult(8'h80, 8'h80, 1'b0, (rep == 0) ? 8 : 9, 1'b0);
        start = 1'b0;
        tick();
        tick();
        checkOutput("b2b_idle", {busy, done}, 0);

        applyStimulus(8'hFF, 8'hFF, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", {cout, sum}, 0);
        last_result = '0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);

        for (int i = 0; i < 20; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            applyStimulus(rx, ry, rc);
            waitResult(rx, ry, rc, 8, 1'b0);
            if ($urandom_range(1, 0) == 1) tick();
        end
        tick();

        for (int i = 0; i < 32; i++) begin
            runSmall(2'(i), 2'(i >> 2), 1'(i >> 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
